// File: rtl/edge_scan_if.sv
// Command/status and pixel-cache handshake bundle for edge_scan_engine.
// master = controller + cache side, slave = the scan engine.
interface edge_scan_if #(
    parameter int unsigned COORD_W = 10,
    parameter int unsigned STEP_W  = 4,
    parameter int unsigned RUN_W   = 3
);
    logic               start;
    logic               abort;
    logic [1:0]         dir;
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic [STEP_W-1:0]  step;
    logic [RUN_W-1:0]   min_run;
    logic               busy;
    logic               done;
    logic               found;
    logic [COORD_W-1:0] found_x;
    logic [COORD_W-1:0] found_y;
    logic               request;
    logic [COORD_W-1:0] req_x;
    logic [COORD_W-1:0] req_y;
    logic               pixel;
    logic               ready;

    modport master (
        output start, abort, dir, x0, y0, x1, y1, step, min_run, pixel, ready,
        input  busy, done, found, found_x, found_y, request, req_x, req_y
    );

    modport slave (
        input  start, abort, dir, x0, y0, x1, y1, step, min_run, pixel, ready,
        output busy, done, found, found_x, found_y, request, req_x, req_y
    );
endinterface

// File: rtl/edge_scan_engine.sv
// Raster edge finder: walks a window in one of four directions, fetching pixels one at a
// time from the cache, and reports the first run of min_run set pixels on a single line.
module edge_scan_engine #(
    parameter int unsigned COORD_W = 10,
    parameter int unsigned STEP_W  = 4,
    parameter int unsigned RUN_W   = 3
) (
    input logic        clk,
    input logic        reset,
    edge_scan_if.slave bus
);
    // One extra bit so stepping past either end of the coordinate range is seen, not aliased
    localparam int unsigned CW = COORD_W + 1;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, EVAL, DONE} state_t;

    state_t             state, state_d;
    logic [CW-1:0]      inner, inner_d, outer, outer_d;
    logic [COORD_W-1:0] in_lo, in_lo_d, in_hi, in_hi_d, out_hi, out_hi_d;
    logic               vert, vert_d, dec, dec_d, invalid, invalid_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [RUN_W-1:0]   min_q, min_d, run_q, run_d;
    logic [COORD_W-1:0] run_x, run_x_d, run_y, run_y_d;
    logic               pix_q, pix_d;
    logic               busy_q, busy_d, done_q, done_d, found_q, found_d, request_q, request_d;
    logic [COORD_W-1:0] found_x_q, found_x_d, found_y_q, found_y_d;
    logic [COORD_W-1:0] req_x_q, req_x_d, req_y_q, req_y_d;

    logic [COORD_W-1:0] cur_x_c, cur_y_c;
    logic [CW-1:0]      inner_nxt_c, outer_nxt_c;
    logic               inner_out_c, outer_out_c, hit_c;
    logic [RUN_W-1:0]   run_nxt_c;

    // Scan position, next-step bounds tests and run-length bookkeeping
    always_comb begin
        cur_x_c     = vert ? outer[COORD_W-1:0] : inner[COORD_W-1:0];
        cur_y_c     = vert ? inner[COORD_W-1:0] : outer[COORD_W-1:0];
        inner_nxt_c = dec ? inner - CW'(step_q) : inner + CW'(step_q);
        inner_out_c = dec ? (inner_nxt_c[COORD_W] || (inner_nxt_c < CW'(in_lo)))
                          : (inner_nxt_c > CW'(in_hi));
        outer_nxt_c = outer + CW'(1);
        outer_out_c = outer_nxt_c > CW'(out_hi);
        run_nxt_c   = pix_q ? ((run_q == '1) ? run_q : run_q + RUN_W'(1)) : '0;
        hit_c       = pix_q && (run_nxt_c >= min_q);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state;
        inner_d   = inner;
        outer_d   = outer;
        in_lo_d   = in_lo;
        in_hi_d   = in_hi;
        out_hi_d  = out_hi;
        vert_d    = vert;
        dec_d     = dec;
        invalid_d = invalid;
        step_d    = step_q;
        min_d     = min_q;
        run_d     = run_q;
        run_x_d   = run_x;
        run_y_d   = run_y;
        pix_d     = pix_q;
        busy_d    = busy_q;
        done_d    = done_q;
        found_d   = found_q;
        found_x_d = found_x_q;
        found_y_d = found_y_q;
        request_d = request_q;
        req_x_d   = req_x_q;
        req_y_d   = req_y_q;

        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    vert_d    = ~bus.dir[1];
                    dec_d     = ~bus.dir[0];
                    in_lo_d   = vert_d ? bus.y0 : bus.x0;
                    in_hi_d   = vert_d ? bus.y1 : bus.x1;
                    out_hi_d  = vert_d ? bus.x1 : bus.y1;
                    inner_d   = CW'(dec_d ? in_hi_d : in_lo_d);
                    outer_d   = CW'(vert_d ? bus.x0 : bus.y0);
                    step_d    = (bus.step == '0) ? STEP_W'(1) : bus.step;
                    min_d     = (bus.min_run == '0) ? RUN_W'(1) : bus.min_run;
                    invalid_d = (bus.x0 > bus.x1) || (bus.y0 > bus.y1);
                    run_d     = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    found_d   = 1'b0;
                    found_x_d = '0;
                    found_y_d = '0;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (bus.abort || invalid) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    request_d = 1'b1;
                    req_x_d   = cur_x_c;
                    req_y_d   = cur_y_c;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (bus.abort) begin
                    request_d = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end else if (bus.ready) begin
                    request_d = 1'b0;
                    pix_d     = bus.pixel;
                    state_d   = EVAL;
                end
            end
            EVAL: begin
                if (bus.abort) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (hit_c) begin
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    found_d   = 1'b1;
                    found_x_d = (run_q == '0) ? cur_x_c : run_x;
                    found_y_d = (run_q == '0) ? cur_y_c : run_y;
                    state_d   = DONE;
                end else begin
                    if (pix_q && (run_q == '0)) begin
                        run_x_d = cur_x_c;
                        run_y_d = cur_y_c;
                    end
                    // Line wrap: restart the inner axis and never carry a run across lines
                    if (inner_out_c) begin
                        inner_d = CW'(dec ? in_hi : in_lo);
                        outer_d = outer_nxt_c;
                        run_d   = '0;
                        if (outer_out_c) begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            state_d = REQ;
                        end
                    end else begin
                        inner_d = inner_nxt_c;
                        run_d   = run_nxt_c;
                        state_d = REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            inner     <= '0;
            outer     <= '0;
            in_lo     <= '0;
            in_hi     <= '0;
            out_hi    <= '0;
            vert      <= 1'b0;
            dec       <= 1'b0;
            invalid   <= 1'b0;
            step_q    <= '0;
            min_q     <= '0;
            run_q     <= '0;
            run_x     <= '0;
            run_y     <= '0;
            pix_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            found_q   <= 1'b0;
            found_x_q <= '0;
            found_y_q <= '0;
            request_q <= 1'b0;
            req_x_q   <= '0;
            req_y_q   <= '0;
        end else begin
            state     <= state_d;
            inner     <= inner_d;
            outer     <= outer_d;
            in_lo     <= in_lo_d;
            in_hi     <= in_hi_d;
            out_hi    <= out_hi_d;
            vert      <= vert_d;
            dec       <= dec_d;
            invalid   <= invalid_d;
            step_q    <= step_d;
            min_q     <= min_d;
            run_q     <= run_d;
            run_x     <= run_x_d;
            run_y     <= run_y_d;
            pix_q     <= pix_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            found_q   <= found_d;
            found_x_q <= found_x_d;
            found_y_q <= found_y_d;
            request_q <= request_d;
            req_x_q   <= req_x_d;
            req_y_q   <= req_y_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.found   = found_q;
    assign bus.found_x = found_x_q;
    assign bus.found_y = found_y_q;
    assign bus.request = request_q;
    assign bus.req_x   = req_x_q;
    assign bus.req_y   = req_y_q;
endmodule

// File: tb/tb_edge_scan_engine.sv
// Directed bench for edge_scan_engine: a reference scan model fills a scoreboard per scan and
// a randomly-delayed cache responder serves pixels from a sparse image.
module tb_edge_scan_engine;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    edge_scan_if #(.COORD_W(10), .STEP_W(4), .RUN_W(3)) bus ();
    edge_scan_engine #(.COORD_W(10), .STEP_W(4), .RUN_W(3)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        bit found;
        int fx;
        int fy;
        int nreq;
    } exp_t;

    exp_t sb[$];
    bit   img[int];
    int   tests = 0;
    int   fails = 0;
    int   req_total = 0;
    int   ready_total = 0;
    int   seen32 = 0;
    bit   stray = 1'b0;

    function automatic int key(int x, int y);
        return y * 4096 + x;
    endfunction

    function automatic bit img_get(int x, int y);
        return img.exists(key(x, y)) ? img[key(x, y)] : 1'b0;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference: walk the window in scan order on integers
    task automatic model(input int d, input int x0, input int y0, input int x1, input int y1,
                         input int st, input int mr, output exp_t e);
        int s, m, olo, ohi, ilo, ihi, run, sx, sy, x, y, i;
        bit vert, dec;
        e.found = 1'b0; e.fx = 0; e.fy = 0; e.nreq = 0;
        sx = 0; sy = 0;
        if (x0 > x1 || y0 > y1) return;
        s = (st == 0) ? 1 : st;
        m = (mr == 0) ? 1 : mr;
        vert = (d < 2);
        dec = (d == 0) || (d == 2);
        olo = vert ? x0 : y0; ohi = vert ? x1 : y1;
        ilo = vert ? y0 : x0; ihi = vert ? y1 : x1;
        for (int o = olo; o <= ohi; o++) begin
            run = 0;
            i = dec ? ihi : ilo;
            while (i >= ilo && i <= ihi) begin
                x = vert ? o : i;
                y = vert ? i : o;
                e.nreq++;
                if (img_get(x, y)) begin
                    if (run == 0) begin sx = x; sy = y; end
                    run++;
                    if (run >= m) begin
                        e.found = 1'b1; e.fx = sx; e.fy = sy;
                        return;
                    end
                end else begin
                    run = 0;
                end
                i = dec ? i - s : i + s;
            end
        end
    endtask

    // Cache responder: random 0-5 cycle latency, checks request coordinates hold steady
    initial begin
        bit active;
        int wcnt;
        logic [9:0] hx, hy;
        active = 1'b0; wcnt = 0; hx = '0; hy = '0;
        bus.ready = 1'b0;
        bus.pixel = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.ready = 1'b0;
            bus.pixel = 1'($urandom);
            if (bus.request === 1'b1) begin
                if (!active) begin
                    active = 1'b1;
                    hx = bus.req_x; hy = bus.req_y;
                    wcnt = $urandom_range(0, 5);
                    req_total++;
                    if (hx == 10'd3 && hy == 10'd2) seen32++;
                end else begin
                    chk("req_stable", {12'd0, bus.req_x, bus.req_y}, {12'd0, hx, hy});
                end
                if (wcnt == 0) begin
                    bus.ready = 1'b1;
                    bus.pixel = img_get(int'(hx), int'(hy));
                    active = 1'b0;
                    ready_total++;
                end else begin
                    wcnt--;
                end
            end else begin
                active = 1'b0;
                if (stray) begin bus.ready = 1'b1; bus.pixel = 1'b1; end
            end
        end
    end

    task automatic do_start(int d, int x0, int y0, int x1, int y1, int st, int mr);
        bus.dir = 2'(d);
        bus.x0 = 10'(x0); bus.y0 = 10'(y0);
        bus.x1 = 10'(x1); bus.y1 = 10'(y1);
        bus.step = 4'(st); bus.min_run = 3'(mr);
        bus.start = 1'b1;
        @(posedge clk); #2;
        bus.start = 1'b0;
    endtask

    task automatic run_scan(string tag, int d, int x0, int y0, int x1, int y1, int st, int mr,
                            bit mid_start, output int cyc);
        exp_t e, got_e;
        int base;
        bit got;
        model(d, x0, y0, x1, y1, st, mr, e);
        sb.push_back(e);
        base = req_total;
        do_start(d, x0, y0, x1, y1, st, mr);
        chk({tag, "_busy_on_start"}, bus.busy, 1);
        chk({tag, "_done_cleared"}, bus.done, 0);
        cyc = 0; got = 1'b0;
        while (cyc < 20000) begin
            if (bus.done === 1'b1) begin got = 1'b1; break; end
            bus.start = mid_start && (cyc == 5);
            bus.dir = (mid_start && cyc == 5) ? ~2'(d) : 2'(d);
            @(posedge clk); #2;
            cyc++;
        end
        bus.start = 1'b0;
        bus.dir = 2'(d);
        chk({tag, "_done_seen"}, got, 1);
        got_e = sb.pop_front();
        chk({tag, "_found"}, bus.found, got_e.found);
        chk({tag, "_found_x"}, bus.found_x, got_e.fx);
        chk({tag, "_found_y"}, bus.found_y, got_e.fy);
        chk({tag, "_nreq"}, req_total - base, got_e.nreq);
        chk({tag, "_busy_off"}, bus.busy, 0);
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_found"}, bus.found, 0);
        chk({tag, "_request"}, bus.request, 0);
        chk({tag, "_found_xy"}, {12'd0, bus.found_x, bus.found_y}, 0);
        chk({tag, "_req_xy"}, {12'd0, bus.req_x, bus.req_y}, 0);
    endtask

    initial begin
        int cyc, base, rbase, s32;
        reset = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.dir = 2'd0;
        bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0;
        bus.step = '0; bus.min_run = '0;
        repeat (3) @(posedge clk);
        #2;
        chk_all_zero("reset");
        reset = 1'b0;
        @(posedge clk); #2;

        // Single pixel, every direction
        img.delete();
        img[key(5, 5)] = 1'b1;
        run_scan("up",    0, 0, 0, 9, 9, 1, 1, 1'b0, cyc);
        run_scan("down",  1, 0, 0, 9, 9, 1, 1, 1'b0, cyc);
        run_scan("left",  2, 0, 0, 9, 9, 1, 1, 1'b0, cyc);
        run_scan("right", 3, 0, 0, 9, 9, 1, 1, 1'b0, cyc);

        // Noise rejection and no run across a line wrap
        img.delete();
        img[key(8, 3)] = 1'b1; img[key(9, 3)] = 1'b1; img[key(0, 4)] = 1'b1;
        img[key(1, 7)] = 1'b1;
        img[key(4, 7)] = 1'b1; img[key(5, 7)] = 1'b1; img[key(6, 7)] = 1'b1;
        run_scan("run3", 3, 0, 0, 9, 9, 0, 3, 1'b0, cyc);

        // Stride 2 skips odd columns
        img.delete();
        img[key(3, 2)] = 1'b1; img[key(4, 2)] = 1'b1;
        s32 = seen32;
        run_scan("step2", 3, 0, 0, 9, 9, 2, 1, 1'b0, cyc);
        chk("step2_skip_3_2", seen32 - s32, 0);

        // All clear, with a start pulse while busy that must be ignored
        img.delete();
        run_scan("clear", 3, 0, 0, 9, 9, 1, 0, 1'b1, cyc);

        // Edges of the coordinate range
        img.delete();
        img[key(0, 1)] = 1'b1;
        run_scan("left_x0", 2, 0, 0, 3, 1, 3, 1, 1'b0, cyc);
        img.delete();
        img[key(1020, 1)] = 1'b1;
        run_scan("right_max", 3, 1020, 0, 1023, 1, 5, 1, 1'b0, cyc);

        // Abort in the same cycle as the 7th ready, which would otherwise complete the run
        img.delete();
        for (int x = 0; x < 10; x++) img[key(x, 0)] = 1'b1;
        base = req_total; rbase = ready_total;
        do_start(3, 0, 0, 9, 9, 1, 7);
        cyc = 0;
        while ((ready_total - rbase) < 7 && cyc < 2000) begin
            @(posedge clk); #2;
            cyc++;
        end
        chk("abort_ready7", ready_total - rbase, 7);
        bus.abort = 1'b1;
        @(posedge clk); #2;
        bus.abort = 1'b0;
        chk("abort_request", bus.request, 0);
        chk("abort_done", bus.done, 1);
        chk("abort_found", bus.found, 0);
        chk("abort_busy", bus.busy, 0);
        stray = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        stray = 1'b0;
        chk("stray_done", bus.done, 1);
        chk("stray_found", bus.found, 0);
        chk("stray_found_xy", {12'd0, bus.found_x, bus.found_y}, 0);
        chk("abort_nreq", req_total - base, 7);

        // Invalid window finishes one cycle after start with no request
        run_scan("invalid", 3, 5, 0, 4, 9, 1, 1, 1'b0, cyc);
        chk("invalid_latency", cyc, 1);

        // Reset in the middle of a scan
        img.delete();
        do_start(3, 0, 0, 9, 9, 1, 1);
        repeat (30) @(posedge clk);
        #2;
        chk("midscan_busy", bus.busy, 1);
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        chk_all_zero("midreset");

        img.delete();
        img[key(3, 5)] = 1'b1;
        run_scan("after_reset", 1, 2, 3, 4, 6, 1, 1, 1'b0, cyc);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
